// File: rtl/band_level_meter_pkg.sv
// Shared definitions for the band level meter: band geometry, sweep FSM encodings
// and small saturating-arithmetic helpers used by the per-band calculator.
package band_level_meter_pkg;

  localparam int NUM_BANDS = 7;
  localparam int BAND_W    = 8;
  localparam int IDX_W     = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [BAND_W-1:0] umax(input logic [BAND_W-1:0] a,
                                             input logic [BAND_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Unsigned subtract that floors at zero instead of wrapping.
  function automatic logic [BAND_W-1:0] sat_sub(input logic [BAND_W-1:0] a,
                                                input logic [BAND_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/band_level_meter_decay_calc.sv
// Combinational per-band update: fast attack, timed decay and peak-hold countdown.
// One instance is time-shared across all bands by the sweep FSM.
module band_decay_calc
  import band_level_meter_pkg::*;
#(
  parameter int DECAY_STEP = 4,
  parameter int PEAK_HOLD  = 30,
  parameter int HOLD_W     = $clog2(PEAK_HOLD + 1)
) (
  input  logic [BAND_W-1:0] x_i,
  input  logic [BAND_W-1:0] lvl_i,
  input  logic [BAND_W-1:0] pk_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              tick_i,
  output logic [BAND_W-1:0] lvl_o,
  output logic [BAND_W-1:0] pk_o,
  output logic [HOLD_W-1:0] hold_o
);

  localparam logic [BAND_W-1:0] STEP_V = BAND_W'(DECAY_STEP);
  localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(PEAK_HOLD);

  logic [BAND_W-1:0] lvl_new;

  always_comb begin
    lvl_new = lvl_i;
    if (x_i >= lvl_i) begin
      lvl_new = x_i;
    end else if (tick_i) begin
      // Decay never undershoots the current input magnitude.
      lvl_new = umax(x_i, sat_sub(lvl_i, STEP_V));
    end
  end

  always_comb begin
    lvl_o  = lvl_new;
    pk_o   = pk_i;
    hold_o = hold_i;
    if (lvl_new >= pk_i) begin
      pk_o   = lvl_new;
      hold_o = HOLD_V;
    end else if (tick_i) begin
      if (hold_i != '0) begin
        hold_o = hold_i - HOLD_W'(1);
      end else begin
        pk_o = umax(lvl_new, sat_sub(pk_i, BAND_W'(1)));
      end
    end
  end

endmodule

// File: rtl/band_level_meter.sv
// Seven-band bar meter: one serial sweep per accepted ready strobe, producing
// display levels with attack/decay and peak markers with hold, plus an update pulse.
module band_level_meter
  import band_level_meter_pkg::*;
#(
  parameter int DECAY_DIV  = 800,
  parameter int DECAY_STEP = 4,
  parameter int PEAK_HOLD  = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        freeze,
  input  logic [7:0]  freq1,
  input  logic [7:0]  freq2,
  input  logic [7:0]  freq3,
  input  logic [7:0]  freq4,
  input  logic [7:0]  freq5,
  input  logic [7:0]  freq6,
  input  logic [7:0]  freq7,
  output logic [55:0] levels,
  output logic [55:0] peaks,
  output logic        update,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int HOLD_W = $clog2(PEAK_HOLD + 1);
  localparam int CNT_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BANDS - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              update_q, update_d;
  logic              busy_q, busy_d;
  logic              snap_en;
  logic              band_we;

  logic [BAND_W-1:0] freq_in [NUM_BANDS];
  logic [BAND_W-1:0] snap_q  [NUM_BANDS];
  logic [BAND_W-1:0] level_q [NUM_BANDS];
  logic [BAND_W-1:0] peak_q  [NUM_BANDS];
  logic [HOLD_W-1:0] hold_q  [NUM_BANDS];

  logic [BAND_W-1:0] cur_x, cur_lvl, cur_pk;
  logic [HOLD_W-1:0] cur_hold;
  logic [BAND_W-1:0] new_lvl, new_pk;
  logic [HOLD_W-1:0] new_hold;

  assign freq_in[0] = freq1;
  assign freq_in[1] = freq2;
  assign freq_in[2] = freq3;
  assign freq_in[3] = freq4;
  assign freq_in[4] = freq5;
  assign freq_in[5] = freq6;
  assign freq_in[6] = freq7;

  // Handshake: ready is a one-cycle strobe with no back-pressure. It is taken only
  // in IDLE with freeze low; strobes during SCAN or DONE are dropped, never queued.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tick_d   = tick_q;
    update_d = update_q;
    busy_d   = busy_q;
    snap_en  = 1'b0;
    band_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready && !freeze) begin
          snap_en = 1'b1;
          idx_d   = '0;
          busy_d  = 1'b1;
          tick_d  = (cnt_q == CNT_LAST);
          cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        band_we = 1'b1;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          update_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        update_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        update_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      update_q <= update_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    cur_x    = '0;
    cur_lvl  = '0;
    cur_pk   = '0;
    cur_hold = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (idx_q == IDX_W'(b)) begin
        cur_x    = snap_q[b];
        cur_lvl  = level_q[b];
        cur_pk   = peak_q[b];
        cur_hold = hold_q[b];
      end
    end
  end

  band_decay_calc #(
    .DECAY_STEP (DECAY_STEP),
    .PEAK_HOLD  (PEAK_HOLD),
    .HOLD_W     (HOLD_W)
  ) u_calc (
    .x_i    (cur_x),
    .lvl_i  (cur_lvl),
    .pk_i   (cur_pk),
    .hold_i (cur_hold),
    .tick_i (tick_q),
    .lvl_o  (new_lvl),
    .pk_o   (new_pk),
    .hold_o (new_hold)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        snap_q[b]  <= '0;
        level_q[b] <= '0;
        peak_q[b]  <= '0;
        hold_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        if (snap_en) begin
          snap_q[b] <= freq_in[b];
        end
        if (band_we && (idx_q == IDX_W'(b))) begin
          level_q[b] <= new_lvl;
          peak_q[b]  <= new_pk;
          hold_q[b]  <= new_hold;
        end
      end
    end
  end

  always_comb begin
    levels = '0;
    peaks  = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      levels[BAND_W*b +: BAND_W] = level_q[b];
      peaks[BAND_W*b +: BAND_W]  = peak_q[b];
    end
  end

  assign update    = update_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_band_level_meter.sv
// Bench for band_level_meter with short decay timing; a behavioural model queues the
// expected bars per accepted strobe and a monitor checks them at each update pulse.
module tb_band_level_meter;
  import band_level_meter_pkg::*;

  localparam int DIV  = 2;
  localparam int STEP = 4;
  localparam int HOLD = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ready = 1'b0;
  logic        freeze = 1'b0;
  logic [55:0] fv = '0;
  logic [55:0] levels, peaks;
  logic        update, busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [111:0] exp_q[$];

  // Reference state, plain integers.
  int m_lev[7], m_pk[7], m_h[7];
  int m_tc  = 0;
  int cyc   = 0;
  int acc_s = 0;
  bit act   = 1'b0;

  band_level_meter #(
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP),
    .PEAK_HOLD  (HOLD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .freeze    (freeze),
    .freq1     (fv[7:0]),
    .freq2     (fv[15:8]),
    .freq3     (fv[23:16]),
    .freq4     (fv[31:24]),
    .freq5     (fv[39:32]),
    .freq6     (fv[47:40]),
    .freq7     (fv[55:48]),
    .levels    (levels),
    .peaks     (peaks),
    .update    (update),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [55:0] act_v, input logic [55:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  function automatic logic [55:0] pack_model(input bit want_peaks);
    logic [55:0] v;
    v = '0;
    for (int b = 0; b < 7; b++) v[8*b +: 8] = want_peaks ? 8'(m_pk[b]) : 8'(m_lev[b]);
    return v;
  endfunction

  function automatic void model_clear();
    for (int b = 0; b < 7; b++) begin
      m_lev[b] = 0;
      m_pk[b]  = 0;
      m_h[b]   = 0;
    end
    m_tc = 0;
    act  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_sweep(input logic [55:0] snap);
    bit tk;
    int x, nl, d;
    tk   = (m_tc == DIV - 1);
    m_tc = tk ? 0 : m_tc + 1;
    for (int b = 0; b < 7; b++) begin
      x = int'(snap[8*b +: 8]);
      if (x >= m_lev[b]) nl = x;
      else if (tk) begin
        d  = m_lev[b] - STEP;
        if (d < 0) d = 0;
        nl = (x > d) ? x : d;
      end else nl = m_lev[b];
      m_lev[b] = nl;
      if (nl >= m_pk[b]) begin
        m_pk[b] = nl;
        m_h[b]  = HOLD;
      end else if (tk && m_h[b] != 0) begin
        m_h[b] = m_h[b] - 1;
      end else if (tk) begin
        m_pk[b] = (m_pk[b] - 1 > nl) ? m_pk[b] - 1 : nl;
      end
    end
    exp_q.push_back({pack_model(1'b1), pack_model(1'b0)});
  endfunction

  // Model: acceptance window and per-sweep arithmetic, evaluated at each sampling edge.
  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_clear();
      end else begin
        cyc++;
        if (ready && !freeze && !(act && (cyc - acc_s <= 8))) begin
          act   = 1'b1;
          acc_s = cyc;
          model_sweep(fv);
        end
      end
    end
  end

  // Monitor: timing of busy/update each cycle, bar values at each update pulse.
  initial begin
    logic [111:0] e;
    logic [55:0]  ok_vec;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("busy", {55'd0, busy}, {55'd0, (act && (cyc - acc_s <= 7))});
        chk("update", {55'd0, update}, {55'd0, (act && (cyc - acc_s == 7))});
        if (update) begin
          if (exp_q.size() == 0) begin
            chk("update_expected", 56'd1, 56'd0);
          end else begin
            e = exp_q.pop_front();
            chk("levels", levels, e[55:0]);
            chk("peaks", peaks, e[111:56]);
            ok_vec = '0;
            for (int b = 0; b < 7; b++) ok_vec[b] = (peaks[8*b +: 8] >= levels[8*b +: 8]);
            chk("peak_ge_level", ok_vec, 56'h7f);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send_ready(input logic [55:0] f);
    wait_cyc(1);
    fv    = f;
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
  endtask

  task automatic sweep(input logic [55:0] f);
    send_ready(f);
    wait_cyc(10);
  endtask

  initial begin
    logic [55:0] f;
    wait_cyc(3);
    chk("reset_levels", levels, 56'd0);
    chk("reset_peaks", peaks, 56'd0);
    chk("reset_flags", {53'd0, busy, update, 1'b0}, 56'd0);
    chk("reset_state", {54'd0, state_dbg}, {54'd0, ST_IDLE});
    reset = 1'b1;
    wait_cyc(2);

    // Attack then decay on band 1.
    sweep(56'd200);
    chk("attack_level1", {48'd0, levels[7:0]}, 56'd200);
    for (int i = 0; i < 4; i++) sweep(56'd0);
    chk("decay_level1", {48'd0, levels[7:0]}, 56'd192);
    chk("hold_peak1", {48'd0, peaks[7:0]}, 56'd200);
    for (int i = 0; i < 3; i++) sweep(56'd0);
    chk("fall_level1", {48'd0, levels[7:0]}, 56'd184);
    chk("fall_peak1", {48'd0, peaks[7:0]}, 56'd198);
    sweep(56'd195);
    sweep(56'd195);
    chk("floor_level1", {48'd0, levels[7:0]}, 56'd195);

    // Second strobe inside the sweep is dropped.
    send_ready(56'd50 << 8);
    wait_cyc(2);
    send_ready(56'd90 << 8);
    wait_cyc(10);
    chk("drop_level2", {48'd0, levels[15:8]}, 56'd50);

    // Level 3 decays to zero without wrapping.
    sweep(56'd3 << 16);
    sweep(56'd0);
    sweep(56'd0);
    chk("sat_level3", {48'd0, levels[23:16]}, 56'd0);

    // Reset at the third edge of a sweep.
    send_ready(56'h07_06_05_04_03_02_01);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    chk("midreset_levels", levels, 56'd0);
    chk("midreset_peaks", peaks, 56'd0);
    chk("midreset_busy", {55'd0, busy}, 56'd0);
    reset = 1'b1;
    wait_cyc(10);
    sweep(56'h70_60_50_40_30_20_10);
    chk("post_reset_levels", levels, 56'h70_60_50_40_30_20_10);

    // Frozen strobes do nothing.
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) sweep(56'hff_ff_ff_ff_ff_ff_ff);
    chk("freeze_levels", levels, pack_model(1'b0));
    chk("freeze_peaks", peaks, pack_model(1'b1));
    freeze = 1'b0;

    // Randomised strobes and spacing.
    for (int i = 0; i < 60; i++) begin
      for (int b = 0; b < 7; b++) f[8*b +: 8] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) f = '0;
      freeze = ($urandom_range(0, 7) == 0);
      send_ready(f);
      wait_cyc($urandom_range(0, 12));
    end
    freeze = 1'b0;
    wait_cyc(12);
    chk("queue_drained", 56'(exp_q.size()), 56'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
